interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
- Prioritising interrupt scheduler for the MiniSRC core.
- Latches edge-triggered device requests and applies a software mask and a global enable.
- Presents one winning request to the control unit at an instruction boundary and supplies the handler vector address.
- Tracks a single non-nested in-service interrupt until the handler signals end-of-interrupt.

Parameters:
- InterruptsNum, 4, number of request lines (1..16).
- IdW, derived, max(1, clog2(InterruptsNum)); width of the interrupt id.
- VectorBase, 32'h0000_0080, vector address of id 0.
- VectorStride, 32'h0000_0008, address spacing between consecutive vectors.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Clear  in  1  synchronous active-high reset.
- IrqIn  in  InterruptsNum  device request lines, already synchronous to Clock.
- MaskWe  in  1  write strobe for the mask register.
- MaskIn  in  InterruptsNum  new mask value (1 = enabled).
- MaskOut  out  InterruptsNum  current mask register.
- EiSet  in  1  set global enable (ei instruction).
- DiSet  in  1  clear global enable (di instruction).
- InstrBoundary  in  1  control unit is at T0 and may divert to an interrupt.
- IntReq  out  1  interrupt request to control unit.
- IntAck  in  1  control unit accepts the request; vector is loaded into PC this cycle.
- VectorAddr  out  32  handler address for ActiveId.
- ActiveId  out  IdW  id of the presented or in-service interrupt.
- InService  out  1  a handler is executing.
- Pending  out  InterruptsNum  pending register, for status reads.

Behaviour:
- Reset (Clear high at a rising edge):
  - state=IDLE, pending=0, mask=0, IE=0, irq_prev=0.
  - Outputs: IntReq=0, ActiveId=0, InService=0, VectorAddr=VectorBase.
  - Clear takes priority over every other input, in any state, mid-handshake included.
- Edge detect: rise[i] = IrqIn[i] & ~irq_prev[i]; irq_prev <= IrqIn every cycle.
- Pending update each cycle:
  - pending[i] <= (pending[i] & ~ackclr[i]) | rise[i], where ackclr is the one-hot of ActiveId while IntAck is accepted in REQ.
  - Set wins over clear in the same cycle.
- Mask: MaskWe loads MaskIn. Pending bits are never cleared by masking.
- Global enable:
  - DiSet clears IE and EiSet sets it; DiSet wins if both are high.
  - Accepting IntAck forces IE=0 in the same edge.
  - EOI in SERVICE forces IE=1 in the same edge; EiSet/DiSet in that same cycle override this.
- Eligibility: elig = pending & mask. winner = lowest set index of elig (index 0 is highest priority).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE→REQ when InstrBoundary & IE & |elig. Capture ActiveId<=winner.
  - REQ→SERVICE on IntAck. Clear pending[ActiveId].
  - REQ→IDLE (withdraw) if IE==0 or elig[ActiveId]==0 and IntAck is low. Pending is retained. IntAck takes precedence over withdraw in the same cycle.
  - SERVICE→IDLE on Eoi (input strobe, 1 bit, driven by the rfi sequence).
  - Eoi outside SERVICE is ignored. IntAck outside REQ is ignored.
- ActiveId is frozen from REQ entry until return to IDLE. A higher-priority arrival during REQ does not change it.
- Outputs:
  - IntReq = (state==REQ), registered Moore output.
  - InService = (state==SERVICE).
  - VectorAddr = VectorBase + ActiveId*VectorStride, 32-bit wrap, combinational from the ActiveId register.
- Latency:
  - Rise sampled at edge k sets pending at edge k.
  - With IE, mask and InstrBoundary already high, state=REQ after edge k+1, so IntReq is visible in the cycle following edge k+1.
- Interrupts are not nested: new arrivals only set pending while in SERVICE.
- Level-held IrqIn produces one pending event only; re-arming requires a low cycle.
- Port list addendum: Eoi  in  1  end-of-interrupt strobe.

Test Plan:
- Reset then idle: Clear=1 for 2 cycles → IntReq=0, Pending=0, MaskOut=0, VectorAddr=32'h80.
- Basic handshake: MaskIn=4'hF, EiSet, InstrBoundary=1, pulse IrqIn[2].
  - IntReq=1 two edges after the pulse, ActiveId=2, VectorAddr=32'h90.
  - IntAck → Pending[2]=0, InService=1, IE=0.
  - Eoi → IDLE, IE=1.
- Priority and freeze: IrqIn[3] and IrqIn[1] rise together → ActiveId=1.
  - IrqIn[0] rising during REQ keeps ActiveId=1.
  - After EOI, id 0 is served next, then id 3.
- Mask/disable withdraw: in REQ with ActiveId=1, write MaskIn=4'b1101.
  - IntReq drops next cycle, Pending[1] stays 1.
  - Unmasking re-raises the request at the next InstrBoundary.
- Simultaneous events:
  - Rise on IrqIn[2] in the same cycle as IntAck for id 2 → Pending[2]=1 afterwards.
  - EiSet+DiSet together → IE=0.
  - Eoi in IDLE → no change.
- Reset mid-operation: Clear in SERVICE and in REQ → IDLE, IntReq=0, InService=0, Pending=0, and no spurious IntReq while IrqIn is held high after Clear releases, until it goes low and rises again.

Source files
------------

// File: rtl/interrupt_controller.sv
// Prioritising interrupt scheduler: edge-latched requests, mask, global enable,
// one non-nested in-service interrupt with handler vector generation.
module interrupt_controller #(
   parameter int          InterruptsNum = 4,
   parameter logic [31:0] VectorBase    = 32'h0000_0080,
   parameter logic [31:0] VectorStride  = 32'h0000_0008,
   localparam int         IdW           = (InterruptsNum > 1) ? $clog2(InterruptsNum) : 1
) (
   input  logic                     Clock,
   input  logic                     Clear,
   input  logic [InterruptsNum-1:0] IrqIn,
   input  logic                     MaskWe,
   input  logic [InterruptsNum-1:0] MaskIn,
   output logic [InterruptsNum-1:0] MaskOut,
   input  logic                     EiSet,
   input  logic                     DiSet,
   input  logic                     InstrBoundary,
   output logic                     IntReq,
   input  logic                     IntAck,
   input  logic                     Eoi,
   output logic [31:0]              VectorAddr,
   output logic [IdW-1:0]           ActiveId,
   output logic                     InService,
   output logic [InterruptsNum-1:0] Pending
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

   state_e                   state_q;
   logic [InterruptsNum-1:0] pending_q, pending_d;
   logic [InterruptsNum-1:0] mask_q;
   logic [InterruptsNum-1:0] irq_prev_q;
   logic [IdW-1:0]           active_id_q;
   logic                     ie_q, ie_d;

   logic [InterruptsNum-1:0] rise, elig, ackclr;
   logic [IdW-1:0]           winner;
   logic                     ack, eoi, withdraw;

   assign rise     = IrqIn & ~irq_prev_q;
   assign elig     = pending_q & mask_q;
   assign ack      = (state_q == REQ) && IntAck;
   assign eoi      = (state_q == SERVICE) && Eoi;
   assign withdraw = (state_q == REQ) && !IntAck && (!ie_q || !elig[active_id_q]);

   // Scan downwards so the lowest set index is the last (winning) assignment.
   always_comb begin
      winner = '0;
      for (int i = InterruptsNum - 1; i >= 0; i--) begin
         if (elig[i]) winner = IdW'(i);
      end
   end

   always_comb begin
      ackclr = '0;
      if (ack) ackclr[active_id_q] = 1'b1;
      pending_d = (pending_q & ~ackclr) | rise;
   end

   // Accepting a request always disables; ei/di override the implicit re-enable at EOI.
   always_comb begin
      ie_d = ie_q;
      if (eoi)   ie_d = 1'b1;
      if (EiSet) ie_d = 1'b1;
      if (DiSet) ie_d = 1'b0;
      if (ack)   ie_d = 1'b0;
   end

   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         mask_q      <= '0;
         irq_prev_q  <= '0;
         ie_q        <= 1'b0;
         active_id_q <= '0;
      end else begin
         pending_q  <= pending_d;
         irq_prev_q <= IrqIn;
         ie_q       <= ie_d;
         if (MaskWe) mask_q <= MaskIn;
         case (state_q)
            IDLE: begin
               if (InstrBoundary && ie_q && |elig) begin
                  state_q     <= REQ;
                  active_id_q <= winner;
               end
            end
            REQ: begin
               if (ack)           state_q <= SERVICE;
               else if (withdraw) state_q <= IDLE;
            end
            SERVICE: begin
               if (eoi) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign IntReq     = (state_q == REQ);
   assign InService  = (state_q == SERVICE);
   assign ActiveId   = active_id_q;
   assign VectorAddr = VectorBase + VectorStride * 32'(active_id_q);
   assign MaskOut    = mask_q;
   assign Pending    = pending_q;

endmodule
